// File: rtl/fetch_stage.sv
// Fetch stage of the 3-stage pipeline.
// Owns the PC, issues one instruction-memory request at a time and fills the
// F/DE pipeline register. It handles downstream stall, redirects from execute,
// discarding of stale responses and insertion of NOP bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_F_DE,
    output logic [31:0] PC_F_DE,
    output logic        valid_F_DE
);

    // REQ: may issue a fetch; WAIT: one request outstanding;
    // HOLD: response parked because decode was stalled when it arrived.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] req_pc_q,  req_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] pc_de_q,   pc_de_d;
    logic        valid_q,   valid_d;

    logic        deliver_s;
    logic [31:0] deliver_ir_s;
    logic [31:0] deliver_pc_s;
    logic [31:0] br_aligned_s;

    // Redirect targets are always word aligned; the low two bits are masked off.
    assign br_aligned_s = br_target & 32'hFFFF_FFFC;

    // The fetch address is the PC itself; a request is only offered in REQ
    // and is suppressed while reset or a redirect is present this cycle.
    always_comb begin
        imem_addr = pc_q;
        if ((state_q == S_REQ) && !rst && !br_taken) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign IR_F_DE    = ir_q;
    assign PC_F_DE    = pc_de_q;
    assign valid_F_DE = valid_q;

    // Next-state logic: redirect first, then the normal REQ/WAIT/HOLD flow,
    // then the F/DE register update (deliver, bubble or hold).
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        hold_ir_d    = hold_ir_q;
        hold_pc_d    = hold_pc_q;
        ir_d         = ir_q;
        pc_de_d      = pc_de_q;
        valid_d      = valid_q;
        deliver_s    = 1'b0;
        deliver_ir_s = 32'h0000_0000;
        deliver_pc_s = 32'h0000_0000;

        if (br_taken) begin
            pc_d    = br_aligned_s;
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    state_d = S_REQ;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // The in-flight response arrives now: drop it on the spot.
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        // Response still pending: remember to throw it away.
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_REQ;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (!stall) begin
                            deliver_s    = 1'b1;
                            deliver_ir_s = imem_rdata;
                            deliver_pc_s = req_pc_q;
                            state_d      = S_REQ;
                        end else begin
                            hold_ir_d = imem_rdata;
                            hold_pc_d = req_pc_q;
                            state_d   = S_HOLD;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        deliver_s    = 1'b1;
                        deliver_ir_s = hold_ir_q;
                        deliver_pc_s = hold_pc_q;
                        state_d      = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            if (deliver_s) begin
                ir_d    = deliver_ir_s;
                pc_de_d = deliver_pc_s;
                valid_d = 1'b1;
            end else if (!stall) begin
                // Nothing to hand over and decode is free: insert a bubble.
                ir_d    = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                // Decode is stalled: keep the F/DE register as it is.
                ir_d    = ir_q;
                valid_d = valid_q;
            end
        end
    end

    // State register with synchronous reset; reset also abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= 32'h0000_0000;
            discard_q <= 1'b0;
            hold_ir_q <= 32'h0000_0000;
            hold_pc_q <= 32'h0000_0000;
            ir_q      <= NOP_INSTR;
            pc_de_q   <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            hold_ir_q <= hold_ir_d;
            hold_pc_q <= hold_pc_d;
            ir_q      <= ir_d;
            pc_de_q   <= pc_de_d;
            valid_q   <= valid_d;
        end
    end

endmodule
